// File: rtl/bus_1553_pkg.sv
// Shared types and helpers for the 1553 bus-controller scheduler.
package bus_1553_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    TXDATA,
    WAIT_STS,
    RXDATA,
    DONE,
    ERR
  } state_e;

  localparam logic SYNC_CMD  = 1'b1;
  localparam logic SYNC_DATA = 1'b0;
  localparam int   MAX_WORDS = 32;

  // Mode codes (subaddress 0 or 31) carry one data word only when bit 4 is set.
  function automatic logic [5:0] word_count(input logic [15:0] cmd);
    logic [5:0] n;
    if (cmd[9:5] == 5'd0 || cmd[9:5] == 5'd31) n = cmd[4] ? 6'd1 : 6'd0;
    else if (cmd[4:0] == 5'd0)                 n = 6'(MAX_WORDS);
    else                                       n = {1'b0, cmd[4:0]};
    return n;
  endfunction

endpackage

// File: rtl/bus_1553_resp_timer.sv
// RT response timer: cleared by start, frozen by hold, counts while cnt_en; never wraps.
module bus_1553_resp_timer #(
  parameter int unsigned CYCLES = 1400
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  input  logic cnt_en,
  output logic expired
);
  localparam int unsigned W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned LAST = (CYCLES > 0) ? CYCLES - 1 : 0;
  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] count_q, count_d;
  logic         counting;

  assign counting = cnt_en && !hold && !start;
  // Fires on the counting cycle that would take the count past its terminal value.
  assign expired  = counting && (count_q == LAST_V);

  always_comb begin
    count_d = count_q;
    if (start)                               count_d = '0;
    else if (counting && count_q != LAST_V)  count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/bus_1553_bc_sched.sv
// MIL-STD-1553 bus-controller message scheduler: command, BC->RT data, status and RT->BC data.
// Optional BUS_1553_BC_RETRY_EN: buffers BC->RT data and replays a failed message once.
module bus_1553_bc_sched
  import bus_1553_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED     = 100000000,
  parameter int unsigned RESP_TIMEOUT_US = 14
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [15:0] s_cmd_tdata,
  input  logic        s_cmd_tvalid,
  output logic        s_cmd_tready,
  input  logic [15:0] s_data_tdata,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  output logic [15:0] m_tx_tdata,
  output logic        m_tx_tuser,
  output logic        m_tx_tvalid,
  input  logic        m_tx_tready,
  input  logic        tx_active,
  input  logic [15:0] s_rx_tdata,
  input  logic        s_rx_tuser,
  input  logic        s_rx_tvalid,
  output logic [15:0] m_rsp_tdata,
  output logic        m_rsp_tvalid,
  input  logic        m_rsp_tready,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_proto
);
  localparam int unsigned TIMEOUT_CYCLES = CLOCK_SPEED / 1000000 * RESP_TIMEOUT_US;

  // Handshakes: a word moves on a rising edge where tvalid and tready are both high;
  // tvalid never waits on tready, and s_rx has no ready so it is taken or dropped.

  state_e           state_q, state_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [4:0]       wcnt_q, wcnt_d;
  logic             proto_q, proto_d;
  logic             out_en_q;
  logic [1:0][15:0] mem_q, mem_d;
  logic             wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [5:0]       n_words;
  logic [4:0]       wcnt_inc;
  logic             last_word, waiting, expired, timer_start;
  logic             tx_hs, push, pop, fifo_full, rx_drop;

`ifdef BUS_1553_BC_RETRY_EN
  logic        retry_q, retry_d, buf_we;
  logic [15:0] buf_q [MAX_WORDS];

  always_ff @(posedge aclk) begin
    if (buf_we) buf_q[wcnt_q] <= s_data_tdata;
  end
`endif

  assign n_words      = word_count(cmd_q);
  assign last_word    = ({1'b0, wcnt_q} == n_words - 6'd1);
  assign wcnt_inc     = (wcnt_q == 5'd31) ? wcnt_q : wcnt_q + 5'd1;
  assign waiting      = (state_q == WAIT_STS) || (state_q == RXDATA);
  assign timer_start  = !waiting || s_rx_tvalid;
  assign busy         = (state_q != IDLE);
  assign fifo_full    = (cnt_q == 2'd2);
  assign rx_drop      = s_rx_tvalid && fifo_full;
  assign m_rsp_tvalid = (cnt_q != 2'd0);
  assign m_rsp_tdata  = mem_q[rd_q];
  assign pop          = m_rsp_tvalid && m_rsp_tready;

  bus_1553_resp_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (aclk),
    .rst    (arst),
    .start  (timer_start),
    .hold   (tx_active),
    .cnt_en (waiting),
    .expired(expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    wcnt_d        = wcnt_q;
    proto_d       = proto_q;
    s_cmd_tready  = 1'b0;
    s_data_tready = 1'b0;
    m_tx_tvalid   = 1'b0;
    m_tx_tdata    = '0;
    m_tx_tuser    = SYNC_DATA;
    tx_hs         = 1'b0;
    push          = 1'b0;
    done          = 1'b0;
    err_timeout   = 1'b0;
    err_proto     = 1'b0;
`ifdef BUS_1553_BC_RETRY_EN
    retry_d       = retry_q;
    buf_we        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        s_cmd_tready = out_en_q;
        if (s_cmd_tvalid && out_en_q) begin
          cmd_d   = s_cmd_tdata;
          state_d = CMD;
`ifdef BUS_1553_BC_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      CMD: begin
        m_tx_tvalid = 1'b1;
        m_tx_tdata  = cmd_q;
        m_tx_tuser  = SYNC_CMD;
        wcnt_d      = '0;
        if (m_tx_tready) state_d = (!cmd_q[10] && n_words != 6'd0) ? TXDATA : WAIT_STS;
      end
      TXDATA: begin
`ifdef BUS_1553_BC_RETRY_EN
        if (retry_q) begin
          m_tx_tvalid = 1'b1;
          m_tx_tdata  = buf_q[wcnt_q];
        end else begin
          m_tx_tvalid   = s_data_tvalid;
          m_tx_tdata    = s_data_tdata;
          s_data_tready = m_tx_tready;
        end
`else
        m_tx_tvalid   = s_data_tvalid;
        m_tx_tdata    = s_data_tdata;
        s_data_tready = m_tx_tready;
`endif
        tx_hs = m_tx_tvalid && m_tx_tready;
`ifdef BUS_1553_BC_RETRY_EN
        buf_we = tx_hs && !retry_q;
`endif
        if (tx_hs) begin
          if (last_word) state_d = WAIT_STS;
          else           wcnt_d  = wcnt_inc;
        end
      end
      WAIT_STS: begin
        wcnt_d = '0;
        if (s_rx_tvalid) begin
          if (!s_rx_tuser || s_rx_tdata[15:11] != cmd_q[15:11] || fifo_full) begin
            state_d = ERR;
            proto_d = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = (cmd_q[10] && n_words != 6'd0) ? RXDATA : DONE;
          end
        end else if (expired) begin
          state_d = ERR;
          proto_d = 1'b0;
        end
      end
      RXDATA: begin
        if (s_rx_tvalid) begin
          if (s_rx_tuser || fifo_full) begin
            state_d = ERR;
            proto_d = 1'b1;
          end else begin
            push = 1'b1;
            if (last_word) state_d = DONE;
            else           wcnt_d  = wcnt_inc;
          end
        end else if (expired) begin
          state_d = ERR;
          proto_d = 1'b0;
        end
      end
      DONE: begin
        done      = 1'b1;
        err_proto = rx_drop;
        state_d   = IDLE;
      end
      ERR: begin
        err_proto = rx_drop;
        state_d   = IDLE;
`ifdef BUS_1553_BC_RETRY_EN
        if (!retry_q) begin
          retry_d = 1'b1;
          state_d = CMD;
        end else begin
          err_timeout = !proto_q;
          err_proto   = proto_q || rx_drop;
        end
`else
        err_timeout = !proto_q;
        err_proto   = proto_q || rx_drop;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry response FIFO; full-FIFO drops are reported by the FSM, not here.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = s_rx_tdata;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      wcnt_q   <= '0;
      proto_q  <= 1'b0;
      out_en_q <= 1'b0;
      mem_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
`ifdef BUS_1553_BC_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wcnt_q   <= wcnt_d;
      proto_q  <= proto_d;
      out_en_q <= 1'b1;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
`ifdef BUS_1553_BC_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_1553_bc_sched.sv
// Directed bench for bus_1553_bc_sched: message flows, timeout, protocol errors, FIFO drop, reset.
module tb_bus_1553_bc_sched;

  logic        aclk;
  logic        arst;
  logic [15:0] s_cmd_tdata;
  logic        s_cmd_tvalid;
  logic        s_cmd_tready;
  logic [15:0] s_data_tdata;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic [15:0] m_tx_tdata;
  logic        m_tx_tuser;
  logic        m_tx_tvalid;
  logic        m_tx_tready;
  logic        tx_active;
  logic [15:0] s_rx_tdata;
  logic        s_rx_tuser;
  logic        s_rx_tvalid;
  logic [15:0] m_rsp_tdata;
  logic        m_rsp_tvalid;
  logic        m_rsp_tready;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_proto;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int pe_cnt = 0;
  int k_hit;

  logic [16:0] tx_exp_q[$];
  logic [15:0] rsp_exp_q[$];

  bus_1553_bc_sched dut (
    .aclk         (aclk),
    .arst         (arst),
    .s_cmd_tdata  (s_cmd_tdata),
    .s_cmd_tvalid (s_cmd_tvalid),
    .s_cmd_tready (s_cmd_tready),
    .s_data_tdata (s_data_tdata),
    .s_data_tvalid(s_data_tvalid),
    .s_data_tready(s_data_tready),
    .m_tx_tdata   (m_tx_tdata),
    .m_tx_tuser   (m_tx_tuser),
    .m_tx_tvalid  (m_tx_tvalid),
    .m_tx_tready  (m_tx_tready),
    .tx_active    (tx_active),
    .s_rx_tdata   (s_rx_tdata),
    .s_rx_tuser   (s_rx_tuser),
    .s_rx_tvalid  (s_rx_tvalid),
    .m_rsp_tdata  (m_rsp_tdata),
    .m_rsp_tvalid (m_rsp_tvalid),
    .m_rsp_tready (m_rsp_tready),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .err_proto    (err_proto)
  );

  // Clock / watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every m_tx and m_rsp handshake is matched against the expected queues.
  always @(negedge aclk) begin
    if (!arst) begin
      if (m_tx_tvalid && m_tx_tready) begin
        if (tx_exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL tx_unexpected: observed 0x%0h expected no word", {m_tx_tuser, m_tx_tdata});
        end else begin
          check("tx_word", {15'd0, m_tx_tuser, m_tx_tdata}, {15'd0, tx_exp_q.pop_front()});
        end
      end
      if (m_rsp_tvalid && m_rsp_tready) begin
        if (rsp_exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL rsp_unexpected: observed 0x%0h expected no word", m_rsp_tdata);
        end else begin
          check("rsp_word", {16'd0, m_rsp_tdata}, {16'd0, rsp_exp_q.pop_front()});
        end
      end
      if (done)        done_cnt++;
      if (err_timeout) to_cnt++;
      if (err_proto)   pe_cnt++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    int i;
    s_cmd_tdata  = c;
    s_cmd_tvalid = 1'b1;
    i = 0;
    while (!s_cmd_tready && i < 20) begin
      tick();
      i++;
    end
    check("cmd_ready", {31'd0, s_cmd_tready}, 32'd1);
    tick();
    s_cmd_tvalid = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] d);
    int i;
    s_data_tdata  = d;
    s_data_tvalid = 1'b1;
    #1;
    i = 0;
    while (!s_data_tready && i < 20) begin
      tick();
      i++;
    end
    check("data_ready", {31'd0, s_data_tready}, 32'd1);
    tick();
    s_data_tvalid = 1'b0;
  endtask

  task automatic send_rx(input logic [15:0] d, input logic u);
    s_rx_tdata  = d;
    s_rx_tuser  = u;
    s_rx_tvalid = 1'b1;
    tick();
    s_rx_tvalid = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int d, input int t, input int p);
    check({tag, "_done_cnt"}, done_cnt, d);
    check({tag, "_to_cnt"}, to_cnt, t);
    check({tag, "_pe_cnt"}, pe_cnt, p);
    check({tag, "_tx_q_left"}, tx_exp_q.size(), 0);
    check({tag, "_rsp_q_left"}, rsp_exp_q.size(), 0);
  endtask

  initial begin
    arst          = 1'b1;
    s_cmd_tdata   = '0;
    s_cmd_tvalid  = 1'b0;
    s_data_tdata  = '0;
    s_data_tvalid = 1'b0;
    m_tx_tready   = 1'b1;
    tx_active     = 1'b0;
    s_rx_tdata    = '0;
    s_rx_tuser    = 1'b0;
    s_rx_tvalid   = 1'b0;
    m_rsp_tready  = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", {31'd0, s_cmd_tready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_valid", {31'd0, m_tx_tvalid}, 32'd0);
    check("rst_rsp_valid", {31'd0, m_rsp_tvalid}, 32'd0);
    #1 arst = 1'b0;
    #1 check("rel_cmd_ready_before_edge", {31'd0, s_cmd_tready}, 32'd0);
    tick();
    check("rel_cmd_ready", {31'd0, s_cmd_tready}, 32'd1);

    // RT1 receive, 2 words
    tx_exp_q.push_back({1'b1, 16'h0822});
    tx_exp_q.push_back({1'b0, 16'hAAAA});
    tx_exp_q.push_back({1'b0, 16'h5555});
    rsp_exp_q.push_back(16'h0800);
    send_cmd(16'h0822);
    tx_active = 1'b1;
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_cmd_blocked", {31'd0, s_cmd_tready}, 32'd0);
    send_data(16'hAAAA);
    send_data(16'h5555);
    repeat (5) tick();
    tx_active = 1'b0;
    repeat (3) tick();
    send_rx(16'h0800, 1'b1);
    check("t1_done", {31'd0, done}, 32'd1);
    tick();
    check("t1_done_end", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);
    check_counts("t1", 1, 0, 0);

    // Words arriving in IDLE are discarded
    send_rx(16'h0800, 1'b1);
    tick();
    check("idle_rx_discard", {31'd0, m_rsp_tvalid}, 32'd0);

    // RT1 transmit, 3 words
    tx_exp_q.push_back({1'b1, 16'h0C23});
    rsp_exp_q.push_back(16'h0800);
    rsp_exp_q.push_back(16'h1111);
    rsp_exp_q.push_back(16'h2222);
    rsp_exp_q.push_back(16'h3333);
    send_cmd(16'h0C23);
    tx_active = 1'b1;
    tick();
    tick();
    tx_active = 1'b0;
    tick();
    send_rx(16'h0800, 1'b1);
    send_rx(16'h1111, 1'b0);
    send_rx(16'h2222, 1'b0);
    send_rx(16'h3333, 1'b0);
    check("t2_done", {31'd0, done}, 32'd1);
    tick();
    check("t2_idle", {31'd0, busy}, 32'd0);
    check_counts("t2", 2, 0, 0);

    // No response: timeout exactly 1400 cycles after tx_active falls
    tx_exp_q.push_back({1'b1, 16'h0821});
    tx_exp_q.push_back({1'b0, 16'hBEEF});
    send_cmd(16'h0821);
    tx_active = 1'b1;
    send_data(16'hBEEF);
    tick();
    tx_active = 1'b0;
    k_hit = 0;
    for (int k = 1; k <= 1500 && k_hit == 0; k++) begin
      tick();
      if (err_timeout) k_hit = k;
    end
    check("t3_timeout_cycle", k_hit, 1400);
    tick();
    check("t3_timeout_pulse_end", {31'd0, err_timeout}, 32'd0);
    check("t3_idle", {31'd0, busy}, 32'd0);
    check_counts("t3", 2, 1, 0);

    // Status from the wrong RT
    tx_exp_q.push_back({1'b1, 16'h0821});
    tx_exp_q.push_back({1'b0, 16'h1234});
    send_cmd(16'h0821);
    tx_active = 1'b1;
    send_data(16'h1234);
    tick();
    tx_active = 1'b0;
    tick();
    send_rx(16'h1000, 1'b1);
    check("t4_err_proto", {31'd0, err_proto}, 32'd1);
    check("t4_no_rsp", {31'd0, m_rsp_tvalid}, 32'd0);
    tick();
    check("t4_err_end", {31'd0, err_proto}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    check_counts("t4", 2, 1, 1);

    // Host stalls m_rsp: two words held, third dropped with err_proto
    m_rsp_tready = 1'b0;
    tx_exp_q.push_back({1'b1, 16'h0C21});
    send_cmd(16'h0C21);
    tx_active = 1'b1;
    tick();
    tx_active = 1'b0;
    tick();
    send_rx(16'h0800, 1'b1);
    send_rx(16'hCAFE, 1'b0);
    check("t5_done", {31'd0, done}, 32'd1);
    s_rx_tdata  = 16'hDEAD;
    s_rx_tuser  = 1'b0;
    s_rx_tvalid = 1'b1;
    #1;
    check("t5_drop_err", {31'd0, err_proto}, 32'd1);
    tick();
    s_rx_tvalid = 1'b0;
    #1;
    check("t5_drop_err_end", {31'd0, err_proto}, 32'd0);
    check("t5_head_word", {16'd0, m_rsp_tdata}, 32'h0800);
    rsp_exp_q.push_back(16'h0800);
    rsp_exp_q.push_back(16'hCAFE);
    m_rsp_tready = 1'b1;
    tick();
    tick();
    check("t5_fifo_drained", {31'd0, m_rsp_tvalid}, 32'd0);
    check_counts("t5", 3, 1, 2);

    // Reset in the middle of TXDATA, then a clean message
    tx_exp_q.push_back({1'b1, 16'h0822});
    tx_exp_q.push_back({1'b0, 16'hAAAA});
    send_cmd(16'h0822);
    tx_active = 1'b1;
    send_data(16'hAAAA);
    s_data_tdata  = 16'h5555;
    s_data_tvalid = 1'b1;
    arst          = 1'b1;
    #1;
    check("t6_rst_tx_valid", {31'd0, m_tx_tvalid}, 32'd0);
    check("t6_rst_tx_data", {16'd0, m_tx_tdata}, 32'd0);
    check("t6_rst_data_ready", {31'd0, s_data_tready}, 32'd0);
    check("t6_rst_cmd_ready", {31'd0, s_cmd_tready}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_errs", {30'd0, err_timeout, err_proto}, 32'd0);
    tick();
    s_data_tvalid = 1'b0;
    tx_active     = 1'b0;
    tick();
    arst = 1'b0;
    #1 check("t6_rel_cmd_ready_before_edge", {31'd0, s_cmd_tready}, 32'd0);
    tick();
    check("t6_rel_cmd_ready", {31'd0, s_cmd_tready}, 32'd1);
    tx_exp_q.push_back({1'b1, 16'h0821});
    tx_exp_q.push_back({1'b0, 16'h0F0F});
    rsp_exp_q.push_back(16'h0800);
    send_cmd(16'h0821);
    tx_active = 1'b1;
    send_data(16'h0F0F);
    tick();
    tx_active = 1'b0;
    tick();
    send_rx(16'h0800, 1'b1);
    check("t6_done", {31'd0, done}, 32'd1);
    tick();
    check("t6_idle", {31'd0, busy}, 32'd0);
    check_counts("t6", 4, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_1553_bc_sched.md
BUS_1553_BC_SCHED -- requirements
Module: bus_1553_bc_sched

Interface
REQ-001 Parameter CLOCK_SPEED, default 100000000: aclk frequency in Hz.
REQ-002 Parameter RESP_TIMEOUT_US, default 14: RT response timeout in microseconds.
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 arst  in  1  asynchronous active-high reset.
REQ-005 s_cmd_tdata/tvalid/tready  in/in/out  16/1/1  command word from the host.
REQ-006 s_data_tdata/tvalid/tready  in/in/out  16/1/1  BC->RT data words.
REQ-007 m_tx_tdata/tuser/tvalid/tready  out/out/out/in  16/1/1/1  words to the 1553 encoder; tuser 1 = command sync, 0 = data sync.
REQ-008 tx_active  in  1  encoder driving the bus (en_o_diff).
REQ-009 s_rx_tdata/tuser/tvalid  in/in/in  16/1/1  decoded words; tuser 1 = status sync; no backpressure.
REQ-010 m_rsp_tdata/tvalid/tready  out/out/in  16/1/1  RT status and RT->BC data to the host.
REQ-011 busy, done, err_timeout, err_proto  out  1 each  busy is a level; the others are single-cycle pulses.

Function
REQ-012 FSM states: IDLE, CMD, TXDATA, WAIT_STS, RXDATA, DONE, ERR.
REQ-013 Word count N = cmd[4:0], with 0 meaning 32.
  - Mode code (cmd[9:5] = 0 or 31): N = cmd[4] ? 1 : 0.
REQ-014 IDLE: s_cmd_tready=1. On a cmd handshake, latch cmd and go to CMD.
REQ-015 CMD: present cmd with tuser=1 on m_tx. On handshake, go to TXDATA if cmd[10]=0 and N>0; otherwise go to WAIT_STS.
REQ-016 TXDATA: pass s_data to m_tx with tuser=0, combinational ready pass-through, N words. On the last handshake, go to WAIT_STS.
REQ-017 WAIT_STS: timer counts CLOCK_SPEED/1000000*RESP_TIMEOUT_US cycles, counting only while tx_active=0.
  - On timer expiry: go to ERR and pulse err_timeout.
  - On rx with tuser=1: require rx[15:11] = cmd[15:11]; on mismatch, or on rx with tuser=0, go to ERR and pulse err_proto.
REQ-018 On a valid status word: forward it to m_rsp.
  - If cmd[10]=1 and N>0, go to RXDATA and restart the timer; otherwise go to DONE.
REQ-019 RXDATA: accept N tuser=0 words and forward each to m_rsp; the timer restarts on every word.
  - tuser=1 word: go to ERR and pulse err_proto.
  - Timer expiry: go to ERR and pulse err_timeout.
  - After word N: go to DONE.
REQ-020 m_rsp is a 2-deep skid FIFO. A word arriving while the FIFO is full is dropped and pulses err_proto.
REQ-021 DONE pulses done for one cycle; ERR pulses its error for one cycle. Both return to IDLE on the next cycle.
REQ-022 busy = (state != IDLE).
REQ-023 An s_cmd handshake is never accepted outside IDLE.
REQ-024 rx words arriving in IDLE, CMD or TXDATA are discarded.
REQ-025 Timer and word counter widths are clog2 of their maxima. Neither counter wraps; both saturate at their terminal value.

Reset
REQ-026 While arst=1, every output is forced to 0 and both the FSM and the FIFO are cleared.
  - Affected outputs: all tready/tvalid, m_tx_tdata, m_tx_tuser, m_rsp_tdata, busy, done, err_*.
  - The FSM goes to IDLE; FIFO contents are discarded.
REQ-027 Reset mid-message abandons the message with no done/err pulse. s_cmd_tready=1 on the first clock edge after arst falls.

Configuration
REQ-028 Macro BUS_1553_BC_RETRY_EN:
  - Defined: a 32x16 buffer captures the TXDATA words. The first ERR of a message instead returns to CMD and replays cmd plus the buffered words; a second ERR reports normally.
  - Undefined: no buffer and no retry; every ERR is reported immediately.

Structure
REQ-029 Package bus_1553_pkg holds the FSM state enum, the SYNC_CMD=1 and SYNC_DATA=0 constants, and a word-count decode function.
REQ-030 Sub-module bus_1553_resp_timer provides the timer: inputs start/hold/count-enable, output expired.

Verification
REQ-031 cmd 0x0822 (RT1 receive, SA1, 2 words), data 0xAAAA, 0x5555; RT status 0x0800 arrives after tx_active falls -> m_tx shows 0x0822/1, 0xAAAA/0, 0x5555/0; m_rsp=0x0800; done pulse.
REQ-032 cmd 0x0C23 (RT1 transmit, 3 words) -> status 0x0800 then 3 data words forwarded in order; done pulse.
REQ-033 cmd 0x0821 with no rx -> err_timeout exactly 1400 cycles after tx_active falls (with the macro: one replay, then err_timeout).
REQ-034 cmd 0x0821; status 0x1000 (RT2) arrives -> err_proto; nothing further forwarded.
REQ-035 cmd 0x0C21; m_rsp_tready held 0 and 3 rx words arrive -> first two held in the FIFO, third dropped, err_proto pulse.
REQ-036 arst asserted during TXDATA -> all outputs 0; after release, s_cmd_tready=1 and the next message completes normally.
